// File: rtl/reg_file_2r1w.sv
// ----------------------------------------------------------------------------
// reg_file_2r1w
// 32-entry general-purpose register file for the CPU datapath.
// Two registered read ports (rs1/rs2) and one write port (rd). x0 reads as
// zero and ignores writes.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset (clears rf and both outputs)
//   en        global enable; when low nothing but reset changes state
//   readEn    read enable shared by both read ports
//   writeEn   write enable
//   rs1, rs2  read addresses
//   rd        write address
//   dataIn    write data
//   readOut1  registered read data, port 1 (1-cycle latency)
//   readOut2  registered read data, port 2 (1-cycle latency)
//
// Configuration macro:
//   WRITE_BYPASS_EN  defined   -> same-address read during a write returns
//                                 dataIn (write-first)
//                    undefined -> read returns the pre-write contents
//                                 (read-first)
// ----------------------------------------------------------------------------
module reg_file_2r1w #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32  // must equal 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              readEn,
    input  logic              writeEn,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] readOut1,
    output logic [DATA_W-1:0] readOut2
);

    // Storage; name and indexing are probed from outside.
    logic [DATA_W-1:0] rf [0:NUM_REGS-1];

    logic [DATA_W-1:0] r_read_out1;
    logic [DATA_W-1:0] r_read_out2;

    logic              w_wr_fire;
    logic              w_rd_fire;
    logic [DATA_W-1:0] w_rd_data1;
    logic [DATA_W-1:0] w_rd_data2;

    // Writes to x0 are dropped here so rf[0] can never leave zero.
    assign w_wr_fire = en & writeEn & (rd != '0);
    assign w_rd_fire = en & readEn;

    // Read data selection, x0 forced to zero on both ports.
    always_comb begin
        w_rd_data1 = '0;
        w_rd_data2 = '0;
        if (rs1 != '0) begin
            w_rd_data1 = rf[rs1];
`ifdef WRITE_BYPASS_EN
            if (w_wr_fire && (rs1 == rd)) begin
                w_rd_data1 = dataIn;
            end
`endif
        end
        if (rs2 != '0) begin
            w_rd_data2 = rf[rs2];
`ifdef WRITE_BYPASS_EN
            if (w_wr_fire && (rs2 == rd)) begin
                w_rd_data2 = dataIn;
            end
`endif
        end
    end

    // Register array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                rf[i] <= '0;
            end
        end else if (w_wr_fire) begin
            rf[rd] <= dataIn;
        end
    end

    // Output registers hold their value whenever a read does not fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read_out1 <= '0;
            r_read_out2 <= '0;
        end else if (w_rd_fire) begin
            r_read_out1 <= w_rd_data1;
            r_read_out2 <= w_rd_data2;
        end
    end

    assign readOut1 = r_read_out1;
    assign readOut2 = r_read_out2;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// ----------------------------------------------------------------------------
// tb_reg_file_2r1w
// Self-checking bench for reg_file_2r1w: directed steps followed by a random
// phase, all checked against a behavioural array model kept in the bench.
// ----------------------------------------------------------------------------
module tb_reg_file_2r1w;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          readEn;
    logic          writeEn;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic [DW-1:0] dataIn;
    logic [DW-1:0] readOut1;
    logic [DW-1:0] readOut2;

    reg_file_2r1w #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .NUM_REGS(NR)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .readEn  (readEn),
        .writeEn (writeEn),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd),
        .dataIn  (dataIn),
        .readOut1(readOut1),
        .readOut2(readOut2)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [DW-1:0] m_rf [NR];
    logic [DW-1:0] m_out1;
    logic [DW-1:0] m_out2;

    int n_total = 0;
    int n_pass  = 0;

    task automatic model_clear();
        for (int i = 0; i < NR; i++) m_rf[i] = '0;
        m_out1 = '0;
        m_out2 = '0;
    endtask

    // One rising edge of the architectural register file.
    task automatic model_edge();
        bit do_write;
        if (reset) begin
            model_clear();
            return;
        end
        do_write = en && writeEn && (rd != 0);
        if (en && readEn) begin
            m_out1 = (rs1 == 0) ? '0 : m_rf[rs1];
            m_out2 = (rs2 == 0) ? '0 : m_rf[rs2];
`ifdef WRITE_BYPASS_EN
            if (do_write && rs1 == rd && rs1 != 0) m_out1 = dataIn;
            if (do_write && rs2 == rd && rs2 != 0) m_out2 = dataIn;
`endif
        end
        if (do_write) m_rf[rd] = dataIn;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock, update model at the edge, sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_out1"}, readOut1, m_out1);
        check({tag, "_out2"}, readOut2, m_out2);
    endtask

    task automatic drive(input logic e, input logic re, input logic we, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] wa,
                         input logic [DW-1:0] d);
        en      = e;
        readEn  = re;
        writeEn = we;
        rs1     = a1;
        rs2     = a2;
        rd      = wa;
        dataIn  = d;
    endtask

    initial begin
        logic [DW-1:0] held;
        int            mism;

        // Reset state
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        model_clear();
        tick();
        tick();
        check_outputs("reset");
        mism = 0;
        for (int i = 0; i < NR; i++) if (dut.rf[i] !== '0) mism++;
        check("reset_rf_nonzero_count", 32'(mism), 32'd0);
        reset = 1'b0;

        // Basic write then read
        drive(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd2, 32'h1215_3524);
        tick();
        check("write_rf2", dut.rf[2], 32'h1215_3524);
        drive(1'b1, 1'b1, 1'b0, 5'd2, 5'd2, 5'd0, '0);
        tick();
        check("read_rf2_out1", readOut1, 32'h1215_3524);
        check("read_rf2_out2", readOut2, 32'h1215_3524);

        // x0 protection
        drive(1'b1, 1'b1, 1'b1, 5'd0, 5'd2, 5'd0, 32'hFFFF_FFFF);
        tick();
        check("x0_rf0", dut.rf[0], 32'h0);
        check("x0_out1", readOut1, 32'h0);
        check_outputs("x0");

        // Global enable low blocks writes and reads
        drive(1'b0, 1'b1, 1'b1, 5'd2, 5'd3, 5'd3, 32'hA5A5_A5A5);
        tick();
        check("en0_rf3", dut.rf[3], 32'h0);
        check_outputs("en0_hold");

        // readEn low holds outputs
        held = readOut2;
        drive(1'b1, 1'b0, 1'b0, 5'd7, 5'd9, 5'd0, '0);
        tick();
        check("readen0_out1", readOut1, 32'h0);
        check("readen0_out2", readOut2, held);

        // Same-address collision
        drive(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd4, 32'h0000_0011);
        tick();
        drive(1'b1, 1'b1, 1'b1, 5'd4, 5'd2, 5'd4, 32'h0000_BEEF);
        tick();
`ifdef WRITE_BYPASS_EN
        check("collision_out1", readOut1, 32'h0000_BEEF);
`else
        check("collision_out1", readOut1, 32'h0000_0011);
`endif
        check("collision_out2", readOut2, 32'h1215_3524);
        drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd4, 5'd0, '0);
        tick();
        check("collision_next_read", readOut1, 32'h0000_BEEF);

        // Sweep rd 2..5 with reads lagging the writes
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, AW'(2 + ((i + 3) % 4)), AW'(2 + ((i + 2) % 4)),
                  AW'(2 + (i % 4)), $urandom);
            tick();
            check_outputs($sformatf("sweep%0d", i));
        end
        for (int i = 2; i <= 5; i++) check($sformatf("sweep_rf%0d", i), dut.rf[i], m_rf[i]);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)),
                  AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)), $urandom);
            if (i % 5 == 0) rs1 = rd;  // provoke collisions
            if (i % 7 == 0) rs2 = rs1;
            tick();
            check_outputs($sformatf("rand%0d", i));
        end
        mism = 0;
        for (int i = 0; i < NR; i++) if (dut.rf[i] !== m_rf[i]) mism++;
        check("rand_rf_mismatch_count", 32'(mism), 32'd0);

        // Asynchronous reset mid-cycle
        drive(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd2, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd2, 5'd2, 5'd0, '0);
        tick();
        check("pre_reset_out1", readOut1, 32'hDEAD_BEEF);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check("async_reset_rf2", dut.rf[2], 32'h0);
        check_outputs("async_reset");
        drive(1'b1, 1'b1, 1'b1, 5'd2, 5'd3, 5'd3, 32'h1234_5678);
        tick();
        check("reset_held_rf3", dut.rf[3], 32'h0);
        check_outputs("reset_held");
        reset = 1'b0;
        tick();
        check_outputs("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
